l1_l2_port_arbiter: RTL and testbench

- Parametrised N-channel arbiter between the L1 miss controllers (L1I, L1D, and future L1 ports) and the single L1->L2 comm buffer.
- Replaces the fixed two-way inst/data access select with a registered grant FSM.
- Grant policy is round-robin or fixed-priority, selected by parameter.
- Adds a dead-cycle release phase and a sticky grant-hold watchdog exception.

---
 rtl/l1_l2_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_l1_l2_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l1_l2_port_arbiter
//  Description : N-channel arbiter between the L1 miss controllers and the
//                single L1->L2 comm buffer. A registered grant FSM
//                (IDLE -> GRANT -> RELEASE -> IDLE) selects one owner,
//                either round-robin or fixed-priority (port 0 highest).
//                It muxes the owner's request onto the dn_* side and demuxes
//                the buffer responses back to the owner only. A sticky
//                watchdog flags grants held for MAX_HOLD cycles or more.
//  Ports       : clock_i / reset_i       clock, sync active-high reset
//                l1_*_i / l1_*_o         packed per-port requester side
//                dn_*_o / dn_*_i         comm-buffer side
//                grant_o                 registered one-hot owner
//                busy_o                  FSM is in GRANT
//                exception_o             sticky grant-hold watchdog flag
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_l2_port_arbiter #(
    parameter int N_PORTS       = 2,
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_HOLD      = 1024
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [N_PORTS-1:0]         l1_req_i,
    input  logic [N_PORTS-1:0]         l1_rw_i,
    input  logic [N_PORTS-1:0]         l1_write_i,
    input  logic [N_PORTS-1:0]         l1_read_i,
    input  logic [N_PORTS*ADDR_W-1:0]  l1_add_i,
    input  logic [N_PORTS*DATA_W-1:0]  l1_data_i,
    output logic [N_PORTS-1:0]         l1_ready_o,
    output logic [N_PORTS-1:0]         l1_write_ready_o,
    output logic [N_PORTS-1:0]         l1_read_ready_o,
    output logic [N_PORTS*DATA_W-1:0]  l1_data_o,
    output logic                       dn_req_o,
    output logic                       dn_rw_o,
    output logic                       dn_write_o,
    output logic                       dn_read_o,
    output logic [ADDR_W-1:0]          dn_add_o,
    output logic [DATA_W-1:0]          dn_data_o,
    input  logic                       dn_ready_i,
    input  logic                       dn_write_ready_i,
    input  logic                       dn_read_ready_i,
    input  logic [DATA_W-1:0]          dn_data_i,
    output logic [N_PORTS-1:0]         grant_o,
    output logic                       busy_o,
    output logic                       exception_o
);

    localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int SUM_W  = PTR_W + 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [HOLD_W-1:0] c_MAX_HOLD = HOLD_W'(MAX_HOLD);
    localparam logic [PTR_W-1:0]  c_LAST     = PTR_W'(N_PORTS - 1);
    localparam logic [SUM_W-1:0]  c_NPORTS   = SUM_W'(N_PORTS);

    logic [1:0]         r_state;
    logic [N_PORTS-1:0] r_grant;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_ptr;
    logic [HOLD_W-1:0]  r_holdCnt;
    logic               r_exception;

    logic               w_found;
    logic [PTR_W-1:0]   w_winIdx;
    logic [PTR_W-1:0]   w_candIdx;
    logic [SUM_W-1:0]   w_sum;
    logic               w_active;
    logic [HOLD_W-1:0]  w_holdInc;

    // Winner search: walk N_PORTS candidates starting at the RR pointer
    // (wrapping by a single subtract), or from port 0 in priority mode.
    always_comb begin
        w_found   = 1'b0;
        w_winIdx  = '0;
        w_candIdx = '0;
        w_sum     = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (PRIORITY_MODE == 1) begin
                w_candIdx = PTR_W'(i);
            end else begin
                w_sum = {1'b0, r_ptr} + SUM_W'(i);
                if (w_sum >= c_NPORTS) begin
                    w_sum = w_sum - c_NPORTS;
                end
                w_candIdx = w_sum[PTR_W-1:0];
            end
            if (!w_found && l1_req_i[w_candIdx]) begin
                w_found  = 1'b1;
                w_winIdx = w_candIdx;
            end
        end
    end

    assign w_holdInc = r_holdCnt + 1'b1;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_holdCnt   <= '0;
            r_exception <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant   <= N_PORTS'(1) << w_winIdx;
                        r_owner   <= w_winIdx;
                        r_holdCnt <= '0;
                        r_state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Saturating hold counter; the flag latches on the edge
                    // the count first reaches MAX_HOLD and the grant stays.
                    if (r_holdCnt != c_MAX_HOLD) begin
                        r_holdCnt <= w_holdInc;
                        if (MAX_HOLD > 0 && w_holdInc == c_MAX_HOLD) begin
                            r_exception <= 1'b1;
                        end
                    end
                    if (!l1_req_i[r_owner]) begin
                        r_grant <= '0;
                        r_state <= S_RELEASE;
                        if (N_PORTS == 1 || r_owner == c_LAST) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= r_owner + 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset also gates the muxes so the downstream request drops at once.
    assign w_active = (r_state == S_GRANT) && !reset_i;

    always_comb begin
        dn_req_o         = 1'b0;
        dn_rw_o          = 1'b0;
        dn_write_o       = 1'b0;
        dn_read_o        = 1'b0;
        dn_add_o         = '0;
        dn_data_o        = '0;
        l1_ready_o       = '0;
        l1_write_ready_o = '0;
        l1_read_ready_o  = '0;
        l1_data_o        = '0;
        if (w_active) begin
            dn_req_o   = l1_req_i[r_owner];
            dn_rw_o    = l1_rw_i[r_owner];
            dn_write_o = l1_write_i[r_owner];
            dn_read_o  = l1_read_i[r_owner];
            dn_add_o   = l1_add_i[r_owner*ADDR_W +: ADDR_W];
            dn_data_o  = l1_data_i[r_owner*DATA_W +: DATA_W];
            l1_ready_o[r_owner]       = dn_ready_i;
            l1_write_ready_o[r_owner] = dn_write_ready_i;
            l1_read_ready_o[r_owner]  = dn_read_ready_i;
            l1_data_o[r_owner*DATA_W +: DATA_W] = dn_data_i;
        end
    end

    assign grant_o     = r_grant;
    assign busy_o      = (r_state == S_GRANT);
    assign exception_o = r_exception;

endmodule
`default_nettype wire

// File: tb/tb_l1_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_l2_port_arbiter
//  Description : Self-checking bench for l1_l2_port_arbiter. Three instances:
//                A (2 ports, round-robin, MAX_HOLD=8), B (4 ports,
//                round-robin, watchdog off), C (4 ports, fixed priority).
//                Grant events are checked by a scoreboard monitor against
//                expected owners and dead-cycle counts queued by stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_l2_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // shared downstream-side stimulus
    logic        dnReady   = 1'b1;
    logic        dnWrReady = 1'b1;
    logic        dnRdReady = 1'b1;
    logic [31:0] dnRData   = 32'hDEADBEEF;

    // instance A: 2 ports
    logic [1:0]  aReq = '0, aRw = 2'b10, aWr = '0, aRd = '0;
    logic [47:0] aAdd   = {24'h000200, 24'h000100};
    logic [63:0] aWData = {32'h2222_2222, 32'h1111_1111};
    logic [1:0]  aL1Ready, aL1WrReady, aL1RdReady, aGrant;
    logic [63:0] aL1Data;
    logic        aDnReq, aDnRw, aDnWr, aDnRd, aBusy, aExc;
    logic [23:0] aDnAdd;
    logic [31:0] aDnData;

    // instances B and C: 4 ports, shared address/data inputs
    logic [3:0]   zero4 = '0;
    logic [95:0]  qAdd   = {24'h000400, 24'h000300, 24'h000200, 24'h000100};
    logic [127:0] qWData = '0;
    logic [3:0]   bReq = '0, cReq = '0;
    logic [3:0]   bL1Ready, bL1WrReady, bL1RdReady, bGrant;
    logic [3:0]   cL1Ready, cL1WrReady, cL1RdReady, cGrant;
    logic [127:0] bL1Data, cL1Data;
    logic         bDnReq, bDnRw, bDnWr, bDnRd, bBusy, bExc;
    logic         cDnReq, cDnRw, cDnWr, cDnRd, cBusy, cExc;
    logic [23:0]  bDnAdd, cDnAdd;
    logic [31:0]  bDnData, cDnData;

    l1_l2_port_arbiter #(.N_PORTS(2), .ADDR_W(24), .DATA_W(32),
                         .PRIORITY_MODE(0), .MAX_HOLD(8)) dutA (
        .clock_i(clk), .reset_i(rst),
        .l1_req_i(aReq), .l1_rw_i(aRw), .l1_write_i(aWr), .l1_read_i(aRd),
        .l1_add_i(aAdd), .l1_data_i(aWData),
        .l1_ready_o(aL1Ready), .l1_write_ready_o(aL1WrReady),
        .l1_read_ready_o(aL1RdReady), .l1_data_o(aL1Data),
        .dn_req_o(aDnReq), .dn_rw_o(aDnRw), .dn_write_o(aDnWr),
        .dn_read_o(aDnRd), .dn_add_o(aDnAdd), .dn_data_o(aDnData),
        .dn_ready_i(dnReady), .dn_write_ready_i(dnWrReady),
        .dn_read_ready_i(dnRdReady), .dn_data_i(dnRData),
        .grant_o(aGrant), .busy_o(aBusy), .exception_o(aExc)
    );

    l1_l2_port_arbiter #(.N_PORTS(4), .ADDR_W(24), .DATA_W(32),
                         .PRIORITY_MODE(0), .MAX_HOLD(0)) dutB (
        .clock_i(clk), .reset_i(rst),
        .l1_req_i(bReq), .l1_rw_i(zero4), .l1_write_i(zero4), .l1_read_i(zero4),
        .l1_add_i(qAdd), .l1_data_i(qWData),
        .l1_ready_o(bL1Ready), .l1_write_ready_o(bL1WrReady),
        .l1_read_ready_o(bL1RdReady), .l1_data_o(bL1Data),
        .dn_req_o(bDnReq), .dn_rw_o(bDnRw), .dn_write_o(bDnWr),
        .dn_read_o(bDnRd), .dn_add_o(bDnAdd), .dn_data_o(bDnData),
        .dn_ready_i(dnReady), .dn_write_ready_i(dnWrReady),
        .dn_read_ready_i(dnRdReady), .dn_data_i(dnRData),
        .grant_o(bGrant), .busy_o(bBusy), .exception_o(bExc)
    );

    l1_l2_port_arbiter #(.N_PORTS(4), .ADDR_W(24), .DATA_W(32),
                         .PRIORITY_MODE(1), .MAX_HOLD(1024)) dutC (
        .clock_i(clk), .reset_i(rst),
        .l1_req_i(cReq), .l1_rw_i(zero4), .l1_write_i(zero4), .l1_read_i(zero4),
        .l1_add_i(qAdd), .l1_data_i(qWData),
        .l1_ready_o(cL1Ready), .l1_write_ready_o(cL1WrReady),
        .l1_read_ready_o(cL1RdReady), .l1_data_o(cL1Data),
        .dn_req_o(cDnReq), .dn_rw_o(cDnRw), .dn_write_o(cDnWr),
        .dn_read_o(cDnRd), .dn_add_o(cDnAdd), .dn_data_o(cDnData),
        .dn_ready_i(dnReady), .dn_write_ready_i(dnWrReady),
        .dn_read_ready_i(dnRdReady), .dn_data_i(dnRData),
        .grant_o(cGrant), .busy_o(cBusy), .exception_o(cExc)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int         inst;
        logic [3:0] grant;
        int         dead;   // expected zero-grant cycles before it; -1 = don't care
    } exp_t;

    exp_t       sbQ[$];
    exp_t       sbE;
    logic [3:0] mG[3];
    logic [3:0] prevG[3];
    int         deadCnt[3];

    task automatic expectGrant(input int inst, input logic [3:0] g, input int dead);
        exp_t e;
        e.inst = inst; e.grant = g; e.dead = dead;
        sbQ.push_back(e);
    endtask

    // Monitor: a new grant is a nonzero grant_o after a zero sample.
    always @(negedge clk) begin
        mG[0] = {2'b00, aGrant};
        mG[1] = bGrant;
        mG[2] = cGrant;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                deadCnt[i] = 0;
                prevG[i]   = '0;
            end else begin
                if (mG[i] != 4'd0 && prevG[i] == 4'd0) begin
                    checks++;
                    if (sbQ.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected inst=%0d got grant=%b expected no grant", i, mG[i]);
                    end else begin
                        sbE = sbQ.pop_front();
                        if (sbE.inst != i || sbE.grant != mG[i] ||
                            (sbE.dead >= 0 && sbE.dead != deadCnt[i])) begin
                            errors++;
                            $display("FAIL sb_grant inst=%0d got grant=%b dead=%0d expected inst=%0d grant=%b dead=%0d",
                                     i, mG[i], deadCnt[i], sbE.inst, sbE.grant, sbE.dead);
                        end
                    end
                    deadCnt[i] = 0;
                end else if (mG[i] == 4'd0) begin
                    deadCnt[i]++;
                end
                prevG[i] = mG[i];
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] curGrant(input int which);
        case (which)
            0:       return {2'b00, aGrant};
            1:       return bGrant;
            default: return cGrant;
        endcase
    endfunction

    task automatic waitGrant(input int which);
        int n;
        n = 0;
        while (curGrant(which) == 4'd0 && n < 12) begin
            tick(1);
            n++;
        end
        if (curGrant(which) == 4'd0) begin
            checks++;
            errors++;
            $display("FAIL wait_grant inst=%0d got no grant in 12 cycles expected a grant", which);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] bSeq[5];

    initial begin
        bSeq[0] = 4'b0001; bSeq[1] = 4'b0010; bSeq[2] = 4'b0100;
        bSeq[3] = 4'b1000; bSeq[4] = 4'b0001;

        // Reset with both A ports requesting
        rst  = 1'b1;
        aReq = 2'b11;
        tick(2);
        check("rst_grant",   64'(aGrant),   64'd0);
        check("rst_dn_req",  64'(aDnReq),   64'd0);
        check("rst_busy",    64'(aBusy),    64'd0);
        check("rst_exc",     64'(aExc),     64'd0);
        check("rst_l1_data", aL1Data,       64'd0);
        check("rst_l1_rdy",  64'(aL1Ready), 64'd0);

        expectGrant(0, 4'b0001, -1);
        rst = 1'b0;
        tick(1);
        check("a_first_grant", 64'(aGrant), 64'h1);
        check("a_first_add",   64'(aDnAdd), 64'h000100);
        check("a_first_req",   64'(aDnReq), 64'h1);

        // Port 0 drops -> RELEASE, IDLE, then port 1
        aReq = 2'b10;
        tick(1);
        check("a_release_grant", 64'(aGrant), 64'h0);
        check("a_release_req",   64'(aDnReq), 64'h0);
        check("a_release_busy",  64'(aBusy),  64'h0);
        expectGrant(0, 4'b0010, 2);
        tick(2);
        check("a_p1_data",     aL1Data,         {32'hDEADBEEF, 32'h0});
        check("a_p1_rdrdy",    64'(aL1RdReady), 64'h2);
        check("a_p1_rdy",      64'(aL1Ready),   64'h2);
        check("a_p1_add",      64'(aDnAdd),     64'h000200);
        check("a_p1_rw",       64'(aDnRw),      64'h1);
        check("a_p1_wdata",    64'(aDnData),    64'h22222222);

        // Port 1 drops while port 0 requests -> port 0 after 2 dead cycles
        expectGrant(0, 4'b0001, 2);
        aReq = 2'b01;
        tick(3);
        check("a_p0_regrant", 64'(aGrant), 64'h1);

        // Watchdog: 8th GRANT edge sets the sticky flag; grant is kept
        tick(7);
        check("a_wdog_before", 64'(aExc), 64'h0);
        tick(1);
        check("a_wdog_rise",   64'(aExc), 64'h1);
        tick(2);
        check("a_wdog_sticky", 64'(aExc),   64'h1);
        check("a_wdog_grant",  64'(aGrant), 64'h1);

        // B: 4-port round-robin, all requesting, owner drops after 3 cycles
        for (int k = 0; k < 5; k++) expectGrant(1, bSeq[k], (k == 0) ? -1 : 2);
        bReq = 4'hF;
        for (int k = 0; k < 5; k++) begin
            waitGrant(1);
            if (k == 2) check("b_p2_add", 64'(bDnAdd), 64'h000300);
            tick(2);
            bReq = 4'hF & ~bGrant;
            tick(1);
            bReq = (k == 4) ? 4'h0 : 4'hF;
        end
        tick(3);
        check("b_wdog_off", 64'(bExc), 64'h0);

        // C: fixed priority; port 1 re-raises in RELEASE and beats port 3
        expectGrant(2, 4'b0010, -1);
        cReq = 4'b1010;
        waitGrant(2);
        tick(2);
        cReq = 4'b1000;
        tick(1);
        check("c_release_grant", 64'(cGrant), 64'h0);
        expectGrant(2, 4'b0010, 2);
        cReq = 4'b1010;
        tick(1);
        waitGrant(2);
        check("c_p1_regain", 64'(cGrant), 64'h2);
        cReq = 4'b0000;
        tick(3);

        // Mid-GRANT reset on A (port 0 still holding, exception set)
        rst = 1'b1;
        #1;
        check("a_midrst_req_now", 64'(aDnReq), 64'h0);
        tick(1);
        check("a_midrst_exc",   64'(aExc),   64'h0);
        check("a_midrst_req",   64'(aDnReq), 64'h0);
        check("a_midrst_grant", 64'(aGrant), 64'h0);
        aReq = 2'b00;
        rst  = 1'b0;
        tick(3);

        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d unmatched expected grants, expected 0", sbQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
